// File: rtl/spart_pkg.sv
// -----------------------------------------------------------------------------
// spart_pkg
// Shared definitions for the SPART serial link blocks (transmitter, receiver,
// baud generator).
//   tx_state_t      transmit sequencer states
//   OVERSAMPLE_DEF  enable ticks per serial bit (baud generator runs at 16x)
//   DATA_BITS_DEF   data bits per frame
//   baud_sel_t      baud select encodings shared with baud generator/receiver
// -----------------------------------------------------------------------------
package spart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } tx_state_t;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int DATA_BITS_DEF  = 8;

   typedef enum logic [1:0] {
      BAUD_4800  = 2'b00,
      BAUD_9600  = 2'b01,
      BAUD_19200 = 2'b10,
      BAUD_38400 = 2'b11
   } baud_sel_t;

endpackage

// File: rtl/spart_tx.sv
// -----------------------------------------------------------------------------
// spart_tx
// Transmit sequencer for the SPART serial link. Serialises one byte per frame
// (1 start bit, DATA_BITS data bits LSB first, 1 stop bit), each bit lasting
// OVERSAMPLE enable ticks. A one-byte holding buffer lets the bus queue the
// next byte while the current frame shifts out; a full buffer at the end of a
// stop bit starts the next frame with no idle gap.
//
// Ports
//   clk      in   system clock, all state changes on posedge
//   rst      in   asynchronous, active-low reset
//   enable   in   one-cycle baud tick at OVERSAMPLE x baud rate
//   tx_wr    in   write strobe, captures tx_data when tbr=1
//   tx_data  in   byte to transmit
//   txd      out  serial output, idle high (registered)
//   tbr      out  transmit buffer ready, holding buffer empty (registered)
//   tx_busy  out  frame in progress (registered, state != IDLE)
//   state    out  current sequencer state, for debug/observation
//
// Write handshake: tbr acts as "ready" and tx_wr as "valid"; a byte is taken
// only on a cycle where both are 1. A write while tbr=0 is dropped and the
// buffer keeps its contents. The buffer->shifter transfer only happens when
// tbr=0, so it never collides with an accepted write.
// -----------------------------------------------------------------------------
module spart_tx
   import spart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 tx_wr,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 txd,
   output logic                 tbr,
   output logic                 tx_busy,
   output tx_state_t            state
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shifter;
   logic [DATA_BITS-1:0] hold;

   logic tick_last;
   logic bit_last;

   assign tick_last = (tick_cnt == TICK_LAST);
   assign bit_last  = (bit_cnt == BIT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shifter  <= '0;
         hold     <= '0;
         tbr      <= 1'b1;
         txd      <= 1'b1;
         tx_busy  <= 1'b0;
      end else begin
         if (tx_wr && tbr) begin
            hold <= tx_data;
            tbr  <= 1'b0;
         end

         if (enable) begin
            case (state)
               IDLE: begin
                  // The enable that finds the buffer full is the first tick
                  // of the start bit, so txd drops right after it.
                  if (!tbr) begin
                     shifter  <= hold;
                     tbr      <= 1'b1;
                     tick_cnt <= '0;
                     txd      <= 1'b0;
                     tx_busy  <= 1'b1;
                     state    <= START;
                  end
               end

               START: begin
                  if (tick_last) begin
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                     txd      <= shifter[0];
                     state    <= DATA;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end

               DATA: begin
                  if (tick_last) begin
                     tick_cnt <= '0;
                     shifter  <= shifter >> 1;
                     if (bit_last) begin
                        bit_cnt <= '0;
                        txd     <= 1'b1;
                        state   <= STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        // shifter[1] is the bit that lands in [0] after this shift
                        txd     <= shifter[1];
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end

               STOP: begin
                  if (tick_last) begin
                     tick_cnt <= '0;
                     if (!tbr) begin
                        shifter <= hold;
                        tbr     <= 1'b1;
                        txd     <= 1'b0;
                        state   <= START;
                     end else begin
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spart_tx.sv
// -----------------------------------------------------------------------------
// tb_spart_tx
// Self-checking bench for spart_tx. A frame-level reference model (tick
// countdown per frame, bit value looked up from the frame position) predicts
// txd/tbr/tx_busy every cycle; a line decoder rebuilds bytes from txd and a
// scoreboard compares them with the expected byte queue.
// -----------------------------------------------------------------------------
module tb_spart_tx;
   import spart_pkg::*;

   logic      clk = 1'b0;
   logic      rst_n = 1'b0;
   logic      enable = 1'b0;
   logic      tx_wr = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic      txd;
   logic      tbr;
   logic      tx_busy;
   tx_state_t state;

   spart_tx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk     (clk),
      .rst     (rst_n),
      .enable  (enable),
      .tx_wr   (tx_wr),
      .tx_data (tx_data),
      .txd     (txd),
      .tbr     (tbr),
      .tx_busy (tx_busy),
      .state   (state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // ---------------- enable generator ----------------
   // mode 0: off, 1: one pulse every en_period cycles, 2: random ~1/3 density
   int en_mode   = 0;
   int en_period = 1;
   int en_cnt    = 0;

   initial forever begin
      @(negedge clk);
      if (en_mode == 1) begin
         enable = (en_cnt == 0);
         en_cnt = (en_cnt + 1 >= en_period) ? 0 : en_cnt + 1;
      end else if (en_mode == 2) begin
         enable = ($urandom_range(0, 2) == 0);
      end else begin
         enable = 1'b0;
      end
   end

   // ---------------- reference model ----------------
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic       model_push = 1'b0;

   logic       m_busy = 1'b0;
   logic       m_tbr  = 1'b1;
   int         m_rem  = 0;     // enable ticks left in the current frame
   logic [7:0] m_buf  = 8'h00;
   logic [7:0] m_cur  = 8'h00;

   initial forever begin
      logic old_tbr;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_busy = 1'b0;
         m_tbr  = 1'b1;
         m_rem  = 0;
         if (model_push) exp_q.delete();
      end else begin
         old_tbr = m_tbr;
         if (enable) begin
            if (m_busy) begin
               m_rem--;
               if (m_rem == 0) m_busy = 1'b0;
            end
            if (!m_busy && !old_tbr) begin
               m_busy = 1'b1;
               m_rem  = 160;
               m_cur  = m_buf;
               m_tbr  = 1'b1;
               if (model_push) exp_q.push_back(m_buf);
            end
         end
         if (tx_wr && old_tbr) begin
            m_buf = tx_data;
            m_tbr = 1'b0;
         end
      end
   end

   function automatic logic model_txd();
      int idx;
      if (!m_busy) return 1'b1;
      idx = (160 - m_rem) / 16;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return m_cur[idx-1];
      return 1'b1;
   endfunction

   // per-cycle comparison of all outputs against the model
   initial forever begin
      @(posedge clk);
      #3;
      chk("cycle_outputs", {29'd0, txd, tbr, tx_busy}, {29'd0, model_txd(), m_tbr, m_busy});
   end

   // ---------------- line decoder ----------------
   logic in_frame = 1'b0;

   initial forever begin
      logic       en_seen;
      int         tcnt;
      int         k;
      logic [7:0] sh;
      @(posedge clk);
      en_seen = enable;
      #3;
      if (!rst_n) begin
         in_frame = 1'b0;
      end else if (!in_frame) begin
         if (txd == 1'b0) begin
            in_frame = 1'b1;
            tcnt     = 0;
            sh       = 8'h00;
         end
      end else if (en_seen) begin
         tcnt++;
         if (tcnt % 16 == 8) begin
            k = tcnt / 16;
            if (k >= 1 && k <= 8) sh[k-1] = txd;
            if (k == 9) begin
               chk("stop_bit", {31'd0, txd}, 32'd1);
               got_q.push_back(sh);
               in_frame = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // called at a negedge; returns at the following negedge
   task automatic write_byte(input logic [7:0] d);
      tx_wr   = 1'b1;
      tx_data = d;
      @(negedge clk);
      tx_wr   = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (!(tx_busy == 1'b0 && tbr == 1'b1 && !in_frame) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) timeout(name);
   endtask

   task automatic wait_tbr(input string name, input int budget);
      int n = 0;
      while (tbr != 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) timeout(name);
   endtask

   task automatic wait_txd_low(input string name, input int budget);
      int n = 0;
      while (txd != 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) timeout(name);
   endtask

   task automatic check_frames(input string name);
      wait_idle({name, "_idle"}, 20000);
      cycles(2);
      chk({name, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk({name, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
      exp_q.delete();
      got_q.delete();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] data;
      int         period;   // clk cycles between enable pulses
      logic [9:0] bits;     // line value per bit, [0]=start ... [9]=stop
      int         width;    // clk cycles from start edge to first high level
   } vec_t;

   vec_t vecs[5];

   // ---------------- watchdog ----------------
   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not complete");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      vecs[0] = '{data: 8'h55, period: 1,  bits: 10'b1010101010, width: 16};
      vecs[1] = '{data: 8'h55, period: 13, bits: 10'b1010101010, width: 208};
      vecs[2] = '{data: 8'hA3, period: 1,  bits: 10'b1101000110, width: 16};
      vecs[3] = '{data: 8'h00, period: 4,  bits: 10'b1000000000, width: 576};
      vecs[4] = '{data: 8'hFF, period: 2,  bits: 10'b1111111110, width: 32};

      // reset held 5 cycles, then idle with enable every cycle
      rst_n = 1'b0;
      cycles(5);
      en_mode   = 1;
      en_period = 1;
      rst_n     = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         chk("idle_txd",  {31'd0, txd},     32'd1);
         chk("idle_tbr",  {31'd0, tbr},     32'd1);
         chk("idle_busy", {31'd0, tx_busy}, 32'd0);
      end

      // table-driven single frames
      for (int v = 0; v < 5; v++) begin
         int         p;
         int         w;
         logic [9:0] got_bits;
         p = vecs[v].period;
         en_period = p;
         wait_idle("vec_idle", 5000);
         write_byte(vecs[v].data);
         chk("vec_tbr_after_wr", {31'd0, tbr}, 32'd0);
         exp_q.push_back(vecs[v].data);
         wait_txd_low("vec_start", 20 * p + 4);
         chk("vec_tbr_after_tick", {31'd0, tbr}, 32'd1);
         w = -1;
         got_bits = '0;
         for (int t = 1; t <= 160 * p; t++) begin
            @(negedge clk);
            if (w < 0 && txd == 1'b1) w = t;
            for (int k = 0; k < 10; k++)
               if (t == 16 * p * k + 8 * p) got_bits[k] = txd;
            if (t == 160 * p - 1) chk("vec_busy_last", {31'd0, tx_busy}, 32'd1);
            if (t == 160 * p)     chk("vec_busy_fall", {31'd0, tx_busy}, 32'd0);
         end
         chk("vec_bits",  {22'd0, got_bits}, {22'd0, vecs[v].bits});
         chk("vec_width", w, vecs[v].width);
         check_frames("vec_frames");
      end

      // back-to-back: second byte queued while first frame shifts
      begin
         int c;
         en_period = 1;
         wait_idle("b2b_idle", 5000);
         write_byte(8'hA3);
         wait_tbr("b2b_tbr", 40);
         chk("b2b_busy", {31'd0, tx_busy}, 32'd1);
         c = 0;
         tx_wr   = 1'b1;
         tx_data = 8'h0F;
         @(negedge clk);
         c = 1;
         tx_wr = 1'b0;
         chk("b2b_tbr_full", {31'd0, tbr}, 32'd0);
         while (tx_busy && c < 400) begin
            @(negedge clk);
            c++;
         end
         chk("b2b_busy_len", c, 320);
         exp_q.push_back(8'hA3);
         exp_q.push_back(8'h0F);
         check_frames("b2b_frames");
      end

      // overrun: third write while the buffer is full is dropped
      en_period = 4;
      wait_idle("ovr_idle", 5000);
      write_byte(8'h11);
      wait_tbr("ovr_tbr", 100);
      write_byte(8'h22);
      chk("ovr_tbr_full", {31'd0, tbr}, 32'd0);
      write_byte(8'h33);
      chk("ovr_tbr_still_full", {31'd0, tbr}, 32'd0);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      check_frames("ovr_frames");

      // reset in the middle of data bit 3 of 0xFF
      en_period = 1;
      wait_idle("rst_idle", 5000);
      write_byte(8'hFF);
      wait_txd_low("rst_start", 40);
      cycles(70);
      chk("rst_state_data", {30'd0, state}, {30'd0, DATA});
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_txd",  {31'd0, txd},     32'd1);
      chk("rst_tbr",  {31'd0, tbr},     32'd1);
      chk("rst_busy", {31'd0, tx_busy}, 32'd0);
      @(negedge clk);
      cycles(3);
      rst_n = 1'b1;
      cycles(2);
      write_byte(8'h00);
      exp_q.push_back(8'h00);
      check_frames("rst_frames");

      // randomized writes against random enable density
      model_push = 1'b1;
      en_mode    = 2;
      for (int i = 0; i < 40; i++) begin
         cycles($urandom_range(0, 300));
         write_byte(8'($urandom_range(0, 255)));
      end
      en_mode   = 1;
      en_period = 1;
      check_frames("rand_frames");
      model_push = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
